// File: rtl/esp32_led_pkg.sv
// Shared definitions for the LED blink sequencer: register map, CTRL bit
// positions and FSM state encoding.
package esp32_led_pkg;

    localparam logic [1:0] REG_CTRL  = 2'd0;
    localparam logic [1:0] REG_ON    = 2'd1;
    localparam logic [1:0] REG_OFF   = 2'd2;
    localparam logic [1:0] REG_COUNT = 2'd3;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_BIT = 1;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_ON_ENC   = 2'd1;
    localparam logic [1:0] ST_OFF_ENC  = 2'd2;
    localparam logic [1:0] ST_DONE_ENC = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_ON   = ST_ON_ENC,
        ST_OFF  = ST_OFF_ENC,
        ST_DONE = ST_DONE_ENC
    } led_state_e;

endpackage

// File: rtl/esp32_led_phase_timer.sv
// Loadable down-counter; expired is high in the last cycle of a phase, so a
// load of N (or 0) yields a max(N,1)-cycle phase.
module esp32_led_phase_timer #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expired = (count <= CNT_W'(1));

endmodule

// File: rtl/esp32_led_blink_ctrl.sv
// Autonomous LED sequencer: configured over a 4-register Avalon-MM slave,
// drives the LED PIO slave with single-cycle write pulses.
module esp32_led_blink_ctrl
    import esp32_led_pkg::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned DEF_ON  = 25_000_000,
    parameter int unsigned DEF_OFF = 25_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  cfg_address,
    input  logic        cfg_chipselect,
    input  logic        cfg_write_n,
    input  logic [31:0] cfg_writedata,
    output logic [31:0] cfg_readdata,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata,
    output logic        done
);

    logic [1:0]       ctrl_q;
    logic [CNT_W-1:0] on_ticks_q;
    logic [CNT_W-1:0] off_ticks_q;
    logic [15:0]      count_q;
    logic [15:0]      blink_cnt_q, blink_cnt_d;
    logic             done_q, done_d;
    led_state_e       state_q, state_d;
    logic             wr_d, level_d;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             expired;
    logic             en, mode, cfg_we;

    assign en     = ctrl_q[CTRL_EN_BIT];
    assign mode   = ctrl_q[CTRL_MODE_BIT];
    assign cfg_we = cfg_chipselect && !cfg_write_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q      <= '0;
            on_ticks_q  <= CNT_W'(DEF_ON);
            off_ticks_q <= CNT_W'(DEF_OFF);
            count_q     <= '0;
        end else if (cfg_we) begin
            case (cfg_address)
                REG_CTRL:  ctrl_q      <= cfg_writedata[1:0];
                REG_ON:    on_ticks_q  <= cfg_writedata[CNT_W-1:0];
                REG_OFF:   off_ticks_q <= cfg_writedata[CNT_W-1:0];
                REG_COUNT: count_q     <= cfg_writedata[15:0];
            endcase
        end
    end

    // NOTE: every always_comb output gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        cfg_readdata = '0;
        case (cfg_address)
            REG_CTRL:  cfg_readdata[1:0]       = ctrl_q;
            REG_ON:    cfg_readdata[CNT_W-1:0] = on_ticks_q;
            REG_OFF:   cfg_readdata[CNT_W-1:0] = off_ticks_q;
            REG_COUNT: cfg_readdata            = {done_q, 15'b0, blink_cnt_q};
        endcase
    end

    esp32_led_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .expired  (expired)
    );

    always_comb begin
        state_d     = state_q;
        wr_d        = 1'b0;
        level_d     = pio_writedata[0];
        blink_cnt_d = blink_cnt_q;
        done_d      = done_q;
        load        = 1'b0;
        load_val    = on_ticks_q;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d     = ST_ON;
                    wr_d        = 1'b1;
                    level_d     = 1'b1;
                    blink_cnt_d = '0;
                    done_d      = 1'b0;
                    load        = 1'b1;
                end
            end
            ST_ON: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    wr_d    = 1'b1;
                    level_d = 1'b0;
                end else if (!mode) begin
                    // Static mode keeps the timer primed so a switch to blink
                    // starts a fresh ON phase.
                    load = 1'b1;
                end else if (expired) begin
                    blink_cnt_d = blink_cnt_q + 16'd1;
                    wr_d        = 1'b1;
                    level_d     = 1'b0;
                    if (count_q != '0 && blink_cnt_d >= count_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = ST_OFF;
                        load     = 1'b1;
                        load_val = off_ticks_q;
                    end
                end
            end
            ST_OFF: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    wr_d    = 1'b1;
                    level_d = 1'b0;
                end else if (expired) begin
                    state_d = ST_ON;
                    wr_d    = 1'b1;
                    level_d = 1'b1;
                    load    = 1'b1;
                end
            end
            ST_DONE: begin
                if (!en) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            blink_cnt_q    <= '0;
            done_q         <= 1'b0;
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            pio_writedata  <= '0;
        end else begin
            state_q        <= state_d;
            blink_cnt_q    <= blink_cnt_d;
            done_q         <= done_d;
            pio_chipselect <= wr_d;
            pio_write_n    <= !wr_d;
            pio_writedata  <= {31'b0, level_d};
        end
    end

    assign pio_address = 2'b00;
    assign done        = done_q;

endmodule

// File: tb/tb_esp32_led_blink_ctrl.sv
// Self-checking bench: directed scenarios plus randomized runs, compared
// against an arithmetic model of the pulse schedule and status register.
module tb_esp32_led_blink_ctrl;

    localparam int DEF_TICKS = 25_000_000;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  cfg_address;
    logic        cfg_chipselect;
    logic        cfg_write_n;
    logic [31:0] cfg_writedata;
    logic [31:0] cfg_readdata;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic        done;

    always #5 clk = ~clk;

    esp32_led_blink_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_address    (cfg_address),
        .cfg_chipselect (cfg_chipselect),
        .cfg_write_n    (cfg_write_n),
        .cfg_writedata  (cfg_writedata),
        .cfg_readdata   (cfg_readdata),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata),
        .done           (done)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: register file plus the parameters of the current/last run.
    int          m_ctrl, m_on, m_off, m_count;
    bit          run_on, run_blink, lastd;
    int          run_start, run_a, run_b, run_cnt, stop_at;
    logic [31:0] prev_status;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int max1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    // {done, 15'b0, blink_cnt} as seen after edge c.
    function automatic logic [31:0] status_at(input int c);
        int p, n, cc;
        if (!run_on) return 32'd0;
        if (c < run_start) return prev_status;
        if (!run_blink) return 32'd0;
        cc = (stop_at >= 0 && c >= stop_at) ? stop_at - 1 : c;
        p  = run_a + run_b;
        n  = (cc < run_start + run_a) ? 0 : (cc - run_start - run_a) / p + 1;
        if (run_cnt != 0 && n > run_cnt) n = run_cnt;
        return {(run_cnt != 0 && n >= run_cnt), 15'b0, 16'(n)};
    endfunction

    // Whether a PIO write is visible after edge c, and its data bit.
    function automatic bit pulse_at(input int c, output bit d);
        int p, rel, k, m;
        d = 1'b0;
        if (!run_on || c < run_start) return 1'b0;
        if (c == run_start) begin
            d = 1'b1;
            return 1'b1;
        end
        if (stop_at >= 0 && c >= stop_at) return (c == stop_at);
        if (!run_blink) return 1'b0;
        p   = run_a + run_b;
        rel = c - run_start;
        k   = rel / p;
        m   = rel % p;
        if (run_cnt != 0 && k >= run_cnt) return 1'b0;
        if (m == 0) begin
            d = 1'b1;
            return 1'b1;
        end
        return (m == run_a);
    endfunction

    task automatic step();
        bit          d, hp;
        logic [31:0] s;
        @(posedge clk);
        #1;
        cyc++;
        hp = pulse_at(cyc, d);
        if (hp) lastd = d;
        s = status_at(cyc);
        check($sformatf("pio/done @%0d", cyc),
              64'({pio_address, pio_chipselect, pio_write_n, pio_writedata, done}),
              64'({2'b00, hp, !hp, 31'b0, lastd, s[31]}));
    endtask

    task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
        int e;
        e = cyc + 1;
        cfg_chipselect = 1'b1;
        cfg_write_n    = 1'b0;
        cfg_address    = a;
        cfg_writedata  = d;
        case (a)
            2'd0: begin
                if (d[0] && m_ctrl[0] == 1'b0) begin
                    prev_status = status_at(e);
                    run_on      = 1'b1;
                    run_start   = e + 1;
                    run_blink   = d[1];
                    run_a       = max1(m_on);
                    run_b       = max1(m_off);
                    run_cnt     = m_count;
                    stop_at     = -1;
                end else if (!d[0] && m_ctrl[0] == 1'b1 && run_on) begin
                    if (!status_at(e)[31]) stop_at = e + 1;
                end
                m_ctrl = int'(d[1:0]);
            end
            2'd1: m_on    = int'(d);
            2'd2: m_off   = int'(d);
            2'd3: m_count = int'(d[15:0]);
        endcase
        step();
        cfg_chipselect = 1'b0;
        cfg_write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, input string tag);
        logic [31:0] exp;
        case (a)
            2'd0:    exp = 32'(m_ctrl);
            2'd1:    exp = 32'(m_on);
            2'd2:    exp = 32'(m_off);
            default: exp = status_at(cyc);
        endcase
        cfg_address = a;
        #1;
        check(tag, 64'(cfg_readdata), 64'(exp));
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        run_on  = 1'b0;
        stop_at = -1;
        lastd   = 1'b0;
        m_ctrl  = 0;
        m_on    = DEF_TICKS;
        m_off   = DEF_TICKS;
        m_count = 0;
        step();
        reset = 1'b0;
    endtask

    initial begin
        bit d;
        int len, target;
        cfg_chipselect = 1'b0;
        cfg_write_n    = 1'b1;
        cfg_address    = 2'd0;
        cfg_writedata  = '0;
        prev_status    = '0;
        run_start      = 0;
        run_a          = 1;
        run_b          = 1;
        run_cnt        = 0;
        run_blink      = 1'b0;
        do_reset();
        do_reset();
        rd(2'd0, "reset ctrl");
        rd(2'd1, "reset on_ticks");
        rd(2'd2, "reset off_ticks");
        rd(2'd3, "reset status");

        // Static on: one write of 1, then silence.
        cfg_wr(2'd0, 32'd1);
        for (int i = 0; i < 100; i++) step();
        rd(2'd0, "static ctrl");
        cfg_wr(2'd0, 32'd0);
        for (int i = 0; i < 4; i++) step();
        rd(2'd3, "static stop status");

        // Infinite blink 3/2.
        cfg_wr(2'd1, 32'd3);
        cfg_wr(2'd2, 32'd2);
        cfg_wr(2'd3, 32'd0);
        cfg_wr(2'd0, 32'd3);
        for (int i = 0; i < 36; i++) begin
            step();
            if (i % 3 == 0) rd(2'd3, "infinite blink_cnt");
        end
        // Stop in the cycle an ON pulse is visible so EN drops mid-ON.
        for (int i = 0; i < 20; i++) begin
            if (pulse_at(cyc, d) && d) break;
            step();
        end
        cfg_wr(2'd0, 32'd0);
        for (int i = 0; i < 5; i++) step();
        rd(2'd3, "stop during on status");

        // Zero-length phases: alternate every cycle.
        cfg_wr(2'd1, 32'd0);
        cfg_wr(2'd2, 32'd0);
        cfg_wr(2'd0, 32'd3);
        for (int i = 0; i < 12; i++) step();
        rd(2'd3, "zero ticks blink_cnt");
        cfg_wr(2'd0, 32'd0);
        for (int i = 0; i < 3; i++) step();

        // Finite run of 3 blinks.
        cfg_wr(2'd1, 32'd2);
        cfg_wr(2'd2, 32'd2);
        cfg_wr(2'd3, 32'd3);
        cfg_wr(2'd0, 32'd3);
        for (int i = 0; i < 30; i++) step();
        rd(2'd3, "finite done status");
        cfg_wr(2'd0, 32'd0);
        for (int i = 0; i < 3; i++) step();
        rd(2'd3, "done held in idle");

        // Randomized runs.
        for (int it = 0; it < 8; it++) begin
            int on_v, off_v, cnt_v;
            on_v  = int'($urandom_range(0, 4));
            off_v = int'($urandom_range(0, 4));
            cnt_v = ($urandom_range(0, 3) != 0) ? int'($urandom_range(1, 4)) : 0;
            cfg_wr(2'd1, 32'(on_v));
            cfg_wr(2'd2, 32'(off_v));
            cfg_wr(2'd3, 32'(cnt_v));
            cfg_wr(2'd0, 32'd3);
            len = (cnt_v != 0) ? cnt_v * (max1(on_v) + max1(off_v)) + 4
                               : int'($urandom_range(5, 25));
            for (int i = 0; i < len; i++) begin
                step();
                if (i % 4 == 0) rd(2'd3, "random status");
            end
            rd(2'd3, "random end status");
            cfg_wr(2'd0, 32'd0);
            for (int i = 0; i < 3; i++) step();
        end

        // Reset in the middle of an OFF phase.
        cfg_wr(2'd1, 32'd2);
        cfg_wr(2'd2, 32'd6);
        cfg_wr(2'd3, 32'd0);
        cfg_wr(2'd0, 32'd3);
        target = run_start + run_a + 3;
        for (int i = 0; i < 40 && cyc < target; i++) step();
        do_reset();
        rd(2'd0, "post-reset ctrl");
        rd(2'd1, "post-reset on_ticks");
        rd(2'd2, "post-reset off_ticks");
        rd(2'd3, "post-reset status");
        for (int i = 0; i < 10; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
